// File: rtl/decode_imm_sequencer.sv
// Decode front end: buffers fetched instructions, classifies the head entry for the
// immediate concatenator and registers the decoded result toward rename/dispatch.
module decode_imm_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic [31:0]      cur_inst,
    output logic [1:0]       cat_group,
    output logic             cat_specifier,
    output logic [11:0]      cat_imm_i12,
    output logic [6:0]       cat_imm_s7,
    output logic [4:0]       cat_imm_s5,
    output logic [6:0]       cat_imm_b7,
    output logic [4:0]       cat_imm_b5,
    input  logic [20:0]      cat_imm_out,
    input  logic             cat_use_uj_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [20:0]      out_imm,
    output logic [1:0]       out_group,
    output logic             out_specifier,
    output logic             out_use_uj_rd,
    output logic             out_illegal,
    output logic [PTR_W:0]   fifo_count
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               head_valid, push, pop, illegal;
    entry_t             head;

    assign head_valid = (count != '0);
    assign in_ready   = (count < (PTR_W+1)'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = head_valid && (!out_valid || out_ready);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Head classification; an empty FIFO presents an all-zero word, which decodes as group 00.
    always_comb begin
        cur_inst      = head_valid ? head.inst : 32'h0;
        cat_group     = 2'b00;
        cat_specifier = 1'b0;
        illegal       = 1'b0;
        case (cur_inst[6:0])
            7'b0110011:                         begin cat_group = 2'b01; cat_specifier = 1'b0; end
            7'b0010011, 7'b0000011, 7'b1100111: begin cat_group = 2'b01; cat_specifier = 1'b1; end
            7'b0100011:                         begin cat_group = 2'b10; cat_specifier = 1'b0; end
            7'b1100011:                         begin cat_group = 2'b10; cat_specifier = 1'b1; end
            7'b0110111, 7'b0010111:             begin cat_group = 2'b11; cat_specifier = 1'b0; end
            7'b1101111:                         begin cat_group = 2'b11; cat_specifier = 1'b1; end
            default:                            illegal = 1'b1;
        endcase
        cat_imm_i12 = cur_inst[31:20];
        cat_imm_s7  = cur_inst[31:25];
        cat_imm_s5  = cur_inst[11:7];
        cat_imm_b7  = cur_inst[31:25];
        cat_imm_b5  = cur_inst[11:7];
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
    end

    // Pointers are PTR_W wide, so the increment wraps modulo DEPTH on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            out_valid     <= 1'b0;
            out_inst      <= '0;
            out_pc        <= '0;
            out_imm       <= '0;
            out_group     <= '0;
            out_specifier <= 1'b0;
            out_use_uj_rd <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (pop) begin
            out_valid     <= 1'b1;
            out_inst      <= head.inst;
            out_pc        <= head.pc;
            out_imm       <= illegal ? 21'h0 : cat_imm_out;
            out_group     <= cat_group;
            out_specifier <= cat_specifier;
            out_use_uj_rd <= cat_use_uj_rd;
            out_illegal   <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_imm_sequencer.sv
// Bench for decode_imm_sequencer: directed scenarios plus random traffic against a
// queue-based reference model; a behavioural concatenator closes the cat_* loop.
module tb_decode_imm_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic        in_ready, cat_specifier, out_valid, out_specifier, out_use_uj_rd, out_illegal;
    logic [31:0] cur_inst, out_inst, out_pc;
    logic [1:0]  cat_group, out_group;
    logic [11:0] cat_imm_i12;
    logic [6:0]  cat_imm_s7, cat_imm_b7;
    logic [4:0]  cat_imm_s5, cat_imm_b5;
    logic [20:0] cat_imm_out, out_imm;
    logic        cat_use_uj_rd;
    logic [2:0]  fifo_count;

    int errors = 0, checks = 0;

    decode_imm_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .cur_inst(cur_inst), .cat_group(cat_group),
        .cat_specifier(cat_specifier), .cat_imm_i12(cat_imm_i12), .cat_imm_s7(cat_imm_s7),
        .cat_imm_s5(cat_imm_s5), .cat_imm_b7(cat_imm_b7), .cat_imm_b5(cat_imm_b5),
        .cat_imm_out(cat_imm_out), .cat_use_uj_rd(cat_use_uj_rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm),
        .out_group(out_group), .out_specifier(out_specifier), .out_use_uj_rd(out_use_uj_rd),
        .out_illegal(out_illegal), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Stand-in concatenator: builds the immediate from the fields the DUT hands it.
    always_comb begin
        cat_imm_out   = '0;
        cat_use_uj_rd = 1'b0;
        case ({cat_group, cat_specifier})
            3'b010, 3'b011: cat_imm_out = {{9{cat_imm_i12[11]}}, cat_imm_i12};
            3'b100: cat_imm_out = {{9{cat_imm_s7[6]}}, cat_imm_s7, cat_imm_s5};
            3'b101: cat_imm_out = {{8{cat_imm_b7[6]}}, cat_imm_b7[6], cat_imm_b5[0],
                                   cat_imm_b7[5:0], cat_imm_b5[4:1], 1'b0};
            3'b110: begin cat_imm_out = {cur_inst[31], cur_inst[31:12]}; cat_use_uj_rd = 1'b1; end
            3'b111: begin
                cat_imm_out = {cur_inst[31], cur_inst[19:12], cur_inst[20], cur_inst[30:21], 1'b0};
                cat_use_uj_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Reference: {group, specifier, illegal} from the opcode table.
    function automatic logic [3:0] ref_class(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:             return 4'b0100;
            7'h13, 7'h03, 7'h67: return 4'b0110;
            7'h23:             return 4'b1000;
            7'h63:             return 4'b1010;
            7'h37, 7'h17:      return 4'b1100;
            7'h6F:             return 4'b1110;
            default:           return 4'b0001;
        endcase
    endfunction

    // Reference immediate computed as a signed integer from the instruction word.
    function automatic logic [20:0] ref_imm(input logic [31:0] inst);
        int v;
        logic [3:0] c = ref_class(inst);
        v = 0;
        case (c[3:1])
            3'b010, 3'b011: v = int'($signed(inst[31:20]));
            3'b100: v = int'($signed({inst[31:25], inst[11:7]}));
            3'b101: v = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            3'b110: v = int'($signed(inst[31:12]));
            3'b111: v = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: v = 0;
        endcase
        return 21'(v);
    endfunction

    logic [63:0] q[$];
    logic        m_valid = 0;
    logic [31:0] m_inst = 0, m_pc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        logic [3:0] c;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("fifo_count", 32'(fifo_count), q.size());
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        if (m_valid) begin
            c = ref_class(m_inst);
            chk("out_inst", out_inst, m_inst);
            chk("out_pc", out_pc, m_pc);
            chk("out_imm", 32'(out_imm), 32'(ref_imm(m_inst)));
            chk("out_group", 32'(out_group), 32'(c[3:2]));
            chk("out_specifier", 32'(out_specifier), 32'(c[1]));
            chk("out_illegal", 32'(out_illegal), 32'(c[0]));
            chk("out_use_uj_rd", 32'(out_use_uj_rd), 32'(c[3:2] == 2'b11));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic [31:0] h;
        logic [3:0]  c;
        logic        do_push, do_pop;
        @(negedge clk);
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        h = (q.size() == 0) ? 32'h0 : q[0][63:32];
        c = ref_class(h);
        chk("cur_inst", cur_inst, h);
        chk("cat_group", 32'(cat_group), (q.size() == 0) ? 0 : 32'(c[3:2]));
        chk("cat_specifier", 32'(cat_specifier), (q.size() == 0) ? 0 : 32'(c[1]));
        chk("cat_fields", {cat_imm_i12, cat_imm_s7, cat_imm_s5, 8'h0},
            {h[31:20], h[31:25], h[11:7], 8'h0});
        chk("cat_b_fields", {20'h0, cat_imm_b7, cat_imm_b5}, {20'h0, h[31:25], h[11:7]});
        if (fl) begin
            q.delete();
            m_valid = 0;
        end else begin
            do_push = v && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && (!m_valid || ordy);
            if (do_pop) begin
                {m_inst, m_pc} = q.pop_front();
                m_valid = 1;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            if (do_push) q.push_back({inst, pc});
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] r = $urandom();
        int k = $urandom_range(0, 9);
        return (k == 9) ? r : {r[31:7], ops[k]};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_imm", 32'(out_imm), 0);
        chk("rst_cur_inst", cur_inst, 0);
        rst_n = 1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);

        // addi x1,x0,-1
        step(1, 32'hFFF00093, 32'h100, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("addi_imm", 32'(out_imm), 32'h1FFFFF);
        chk("addi_group", {30'h0, out_group}, 32'h1);

        // sw, beq, lui back-to-back
        step(1, 32'h00112423, 32'h104, 1, 0);
        step(1, 32'hFE000EE3, 32'h108, 1, 0);
        step(1, 32'h123450B7, 32'h10C, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("lui_use_uj_rd", 32'(out_use_uj_rd), 1);
        chk("lui_imm", 32'(out_imm), 32'h12345);
        step(0, 0, 0, 1, 0);

        // Backpressure until full, then drain across the pointer wrap
        for (int i = 0; i < 6; i++) step(1, rand_inst(), 32'h200 + 4 * i, 0, 0);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

        // Illegal opcode passes through
        step(1, 32'h0000007F, 32'h300, 1, 0);
        step(1, 32'hFFF00093, 32'h304, 1, 0);
        chk("illegal_flag", 32'(out_illegal), 1);
        chk("illegal_imm", 32'(out_imm), 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Flush with a beat presented the same cycle
        for (int i = 0; i < 4; i++) step(1, rand_inst(), 32'h400 + 4 * i, 0, 0);
        step(1, 32'h00000013, 32'h500, 0, 1);
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), rand_inst(), $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1, rand_inst(), 32'h600 + 4 * i, 0, 0);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_count", 32'(fifo_count), 0);
        q.delete();
        m_valid = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), rand_inst(), $urandom(), 1'($urandom_range(0, 1)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
